// File: rtl/char_wr_pkg.sv
// char_wr_pkg: shared states, ASCII constants, widths and address packing for char_line_writer
package char_wr_pkg;
  typedef enum logic [2:0] {IDLE, GRANT, CONV, WR_LABEL, WR_DIGIT, DONE} state_t;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam int DEF_DIGITS = 5;
  localparam int BCD_W = 4 * DEF_DIGITS;
  localparam int VAL_W = 16;
  function automatic logic [13:0] pack_addr(input logic [6:0] line, input logic [6:0] col);
    return {line, col};
  endfunction
endpackage

// File: rtl/char_line_writer_if.sv
// char_line_writer_if: request/value/label inputs and char-RAM write port of char_line_writer
interface char_line_writer_if #(
  parameter int NREQ = 3,
  parameter int LABEL_LEN = 12
);
  logic [NREQ-1:0] req;
  logic [NREQ*16-1:0] value;
  logic [NREQ*LABEL_LEN*8-1:0] label;
  logic [NREQ-1:0] ack;
  logic busy;
  logic wr_en;
  logic [13:0] wr_addr;
  logic [7:0] wr_data;
  modport master (output req, value, label, input ack, busy, wr_en, wr_addr, wr_data);
  modport slave (input req, value, label, output ack, busy, wr_en, wr_addr, wr_data);
endinterface

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: iterative shift/add-3 binary to BCD, one bit per cycle, start/done handshake
module bin2bcd_seq import char_wr_pkg::*; #(
  parameter int BW = BCD_W
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             start,
  input  logic [VAL_W-1:0] din,
  output logic             done,
  output logic [BW-1:0]    bcd
);
  logic [VAL_W-1:0] sh;
  logic [4:0] cnt;
  logic run;
  logic [BW-1:0] adj;
  always_comb begin
    adj = bcd;
    for (int i = 0; i < BW / 4; i++)
      adj[4*i +: 4] = bcd[4*i +: 4] >= 4'd5 ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
  end
  // done flags the last iteration, so the result is complete on the following cycle
  assign done = run && cnt == 5'(VAL_W - 1);
  always_ff @(posedge CLK or negedge reset)
    if (!reset) begin
      sh <= '0;
      cnt <= '0;
      run <= 1'b0;
      bcd <= '0;
    end else if (start) begin
      sh <= din;
      cnt <= '0;
      run <= 1'b1;
      bcd <= '0;
    end else if (run) begin
      bcd <= {adj[BW-2:0], sh[VAL_W-1]};
      sh <= sh << 1;
      cnt <= cnt + 5'd1;
      run <= !done;
    end
endmodule

// File: rtl/char_line_writer.sv
// char_line_writer: round-robin line refresh writer (label + decimal value) into char RAM; CHAR_WR_LZB_EN blanks leading zeros
module char_line_writer import char_wr_pkg::*; #(
  parameter int NREQ = 3,
  parameter int LABEL_LEN = 12,
  parameter int DIGITS = DEF_DIGITS,
  parameter int LINE_STRIDE = 2
) (
  input logic CLK,
  input logic reset,
  char_line_writer_if.slave bus
);
  localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1;
  localparam int LW = 8 * LABEL_LEN;
  localparam int BW = 4 * DIGITS;
  localparam int LAST = LABEL_LEN + DIGITS - 1;
  if (LABEL_LEN + DIGITS > 128) begin : g_len_chk
    $error("LABEL_LEN + DIGITS exceeds the 128 columns of a line");
  end
  state_t state, state_n;
  logic [6:0] col, col_n;
  logic [IW-1:0] idx, rr, sel;
  logic [LW-1:0] label_q;
  logic start, done, we_n, blank;
  logic [BW-1:0] bcd, dsh;
  logic [7:0] lsh, data_n;
  logic [13:0] addr_n;
  logic [NREQ-1:0] ack_n;
  int dp;
  always_comb begin
    sel = '0;
    for (int i = NREQ - 1; i >= 0; i--)
      if (bus.req[(int'(rr) + i) % NREQ]) sel = IW'((int'(rr) + i) % NREQ);
  end
  assign start = state == GRANT && |bus.req;
  bin2bcd_seq #(.BW(BW)) u_conv (
    .CLK,
    .reset,
    .start,
    .din(bus.value[int'(sel)*VAL_W +: VAL_W]),
    .done,
    .bcd
  );
  always_comb begin
    state_n = state;
    col_n = col;
    case (state)
      IDLE: state_n = |bus.req ? GRANT : IDLE;
      GRANT: state_n = |bus.req ? CONV : IDLE;
      CONV: begin
        col_n = '0;
        if (done) state_n = WR_LABEL;
      end
      WR_LABEL: begin
        col_n = col + 7'd1;
        if (col == 7'(LABEL_LEN - 1)) state_n = WR_DIGIT;
      end
      WR_DIGIT: begin
        col_n = col + 7'd1;
        if (col == 7'(LAST)) state_n = DONE;
      end
      default: state_n = IDLE;
    endcase
  end
  // outputs are registered from the next state so they line up with the state they describe
  always_comb begin
    dp = int'(col_n) - LABEL_LEN;
    lsh = 8'(label_q >> (8 * (LABEL_LEN - 1 - int'(col_n))));
    dsh = bcd >> (4 * (DIGITS - 1 - dp));
`ifdef CHAR_WR_LZB_EN
    blank = dsh == '0 && dp != DIGITS - 1;
`else
    blank = 1'b0;
`endif
    we_n = state_n == WR_LABEL || state_n == WR_DIGIT;
    addr_n = we_n ? pack_addr(7'(int'(idx) * LINE_STRIDE), col_n) : '0;
    data_n = !we_n ? 8'h00 : state_n == WR_LABEL ? lsh : blank ? ASCII_SPACE : ASCII_ZERO + {4'h0, dsh[3:0]};
    ack_n = state_n == DONE ? NREQ'(1) << idx : '0;
  end
  always_ff @(posedge CLK or negedge reset)
    if (!reset) begin
      state <= IDLE;
      col <= '0;
      idx <= '0;
      rr <= '0;
      label_q <= '0;
      bus.ack <= '0;
      bus.busy <= 1'b0;
      bus.wr_en <= 1'b0;
      bus.wr_addr <= '0;
      bus.wr_data <= '0;
    end else begin
      state <= state_n;
      col <= col_n;
      if (start) begin
        idx <= sel;
        rr <= sel == IW'(NREQ - 1) ? '0 : sel + IW'(1);
        label_q <= bus.label[int'(sel)*LW +: LW];
      end
      bus.ack <= ack_n;
      bus.busy <= state_n != IDLE;
      bus.wr_en <= we_n;
      bus.wr_addr <= addr_n;
      bus.wr_data <= data_n;
    end
endmodule
